// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: producer/FIFO write-side bundle shared by the write-port arbiter
// master: producers plus FIFO flags (drive req/req_data/req_last/fifo_*, see gnt and write port)
// slave : arbiter (sees requests and flags, drives gnt, write port and status)
interface fifo_wr_arbiter_if #(
  parameter int FIFO_WIDTH = 16,
  parameter int NUM_REQ = 4
);
  localparam int OW = $clog2(NUM_REQ);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0] req_last;
  logic [NUM_REQ-1:0] gnt;
  logic fifo_full;
  logic fifo_almostfull;
  logic fifo_overflow;
  logic fifo_wr_en;
  logic [FIFO_WIDTH-1:0] fifo_data_in;
  logic [OW-1:0] owner;
  logic busy;
  logic err_overflow;
  modport master (
    output req, req_data, req_last, fifo_full, fifo_almostfull, fifo_overflow,
    input gnt, fifo_wr_en, fifo_data_in, owner, busy, err_overflow
  );
  modport slave (
    input req, req_data, req_last, fifo_full, fifo_almostfull, fifo_overflow,
    output gnt, fifo_wr_en, fifo_data_in, owner, busy, err_overflow
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one FIFO write port among NUM_REQ producers
// clk/rst: rising-edge clock, synchronous active-high reset
// bus.req/req_data/req_last in, bus.gnt out (combinational accept)
// bus.fifo_full/almostfull/overflow in, bus.fifo_wr_en/fifo_data_in out (registered)
// bus.owner/busy/err_overflow out (status)
module fifo_wr_arbiter #(
  parameter int FIFO_WIDTH = 16,
  parameter int NUM_REQ = 4,
  parameter int MAX_BURST = 8
) (
  input logic clk,
  input logic rst,
  fifo_wr_arbiter_if.slave bus
);
  localparam int OW = $clog2(NUM_REQ);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BURST = 1'b1;
  logic [0:0] state_q, state_d;
  logic [OW-1:0] owner_q, owner_d, rr_q, rr_d, pick, owner_nxt;
  logic [OW:0] idx;
  logic [7:0] cnt_q, cnt_d;
  logic wr_en_q, wr_en_d, err_q, err_d, acc, done;
  logic [FIFO_WIDTH-1:0] data_q, data_d;
  // lowest offset from rr_q wins: scan offsets high to low so the nearest one is written last
  always_comb begin
    idx = '0;
    pick = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = {1'b0, rr_q} + (OW+1)'(k);
      idx = (idx >= (OW+1)'(NUM_REQ)) ? idx - (OW+1)'(NUM_REQ) : idx;
      pick = bus.req[idx[OW-1:0]] ? idx[OW-1:0] : pick;
    end
  end
  // the almostfull term holds off a word that would land in the last slot behind an in-flight write
  always_comb begin
    acc = ~rst & (state_q == BURST) & bus.req[owner_q] & ~bus.fifo_full & ~(bus.fifo_almostfull & wr_en_q);
    done = (state_q == BURST) & (~bus.req[owner_q] | (acc & (bus.req_last[owner_q] | (cnt_q == 8'(MAX_BURST - 1)))));
    owner_nxt = (owner_q == OW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
    state_d = (state_q == IDLE) ? ((|bus.req) ? BURST : IDLE) : (done ? IDLE : BURST);
    owner_d = ((state_q == IDLE) && (|bus.req)) ? pick : owner_q;
    cnt_d = (state_q == IDLE) ? '0 : cnt_q + 8'(acc);
    rr_d = done ? owner_nxt : rr_q;
    wr_en_d = acc;
    data_d = acc ? bus.req_data[owner_q*FIFO_WIDTH +: FIFO_WIDTH] : data_q;
    err_d = err_q | bus.fifo_overflow;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_q <= '0;
      cnt_q <= '0;
      wr_en_q <= 1'b0;
      data_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q <= rr_d;
      cnt_q <= cnt_d;
      wr_en_q <= wr_en_d;
      data_q <= data_d;
      err_q <= err_d;
    end
  end
  assign bus.gnt = acc ? (NUM_REQ'(1) << owner_q) : '0;
  assign bus.fifo_wr_en = wr_en_q;
  assign bus.fifo_data_in = data_q;
  assign bus.owner = owner_q;
  assign bus.busy = state_q;
  assign bus.err_overflow = err_q;
endmodule
